result_display_scanner: RTL and testbench
=========================================

// Module: result_display_scanner
// PURPOSE
// - Consumer end of the 4-bit math datapath: captures A, B, A+B and A-B, then
//   time-multiplexes them onto a 4-digit common-anode seven-segment display.
// - Sits between math_block outputs and the board display pins; the refresh
//   counter sets the per-digit dwell time.
// PARAMETERS
// - REFRESH_DIV  100000  clock cycles each digit stays lit; legal range >= 1
// PORTS
// - clk      in   1  system clock, rising edge
// - reset    in   1  asynchronous, active-high reset
// - update   in   1  capture strobe; samples A/B/AplusB/AminusB on this edge
// - blank    in   1  1 = all digits off; scanning continues underneath
// - A        in   4  operand A
// - B        in   4  operand B
// - AplusB   in   4  A+B mod 16
// - AminusB  in   4  A-B mod 16
// - anode    out  4  digit enables, active-low; bit k drives digit k
// - seg      out  7  segments {g,f,e,d,c,b,a}, active-low
// - dp       out  1  decimal point, active-low
// BEHAVIOUR
// - One clock domain. Reset is asynchronous and active-high.
// - Reset values:
//   - anode = 4'b1111, seg = 7'b1111111, dp = 1
//   - prescaler = 0, digit index = 0, all four shadow registers = 0
// - Shadow capture: on an edge where update=1, the shadow registers load all
//   four inputs. Otherwise the shadows hold their value.
// - Prescaler: counts 0..REFRESH_DIV-1. On the edge where it equals
//   REFRESH_DIV-1, it wraps to 0 and the digit index advances. Index wraps 3->0.
//   REFRESH_DIV=1 means the index advances every cycle.
// - Digit map: index 0=AminusB, 1=AplusB, 2=B, 3=A.
// - Registered outputs, updated every edge from the current index and shadows:
//   - anode = ~(4'b0001 << index), or 4'b1111 when blank=1
//   - seg = hex pattern of the selected shadow nibble (0-F), or all 1s when blank=1
//   - dp = 0 only when index=0, shadow A < shadow B (unsigned) and blank=0;
//     otherwise dp = 1. This marks a negative difference.
// - Latency:
//   - update edge -> shadow register: 1 cycle
//   - shadow -> seg/anode: 1 further cycle
//   - index change -> anode/seg: 1 cycle
// - update asserted mid-dwell: prescaler and index are not disturbed; the new
//   value appears on the current digit within 2 cycles.
// - update held high: the shadows track the inputs every cycle.
// - blank changes: no effect on prescaler or index; takes effect on the next edge.
// - Reset mid-scan: all state returns to reset values immediately (async).
//   The first lit digit after release is index 0.
// STRUCTURE
// - Shared package holds:
//   - SEG_BLANK = 7'b1111111
//   - the 16-entry hex segment table, e.g. 0=7'b1000000, 1=7'b1111001,
//     8=7'b0000000, F=7'b0001110
//   - digit-index constants DIG_DIFF=0, DIG_SUM=1, DIG_B=2, DIG_A=3
// - Sub-module hex_to_7seg: combinational 4-bit -> 7-bit decoder; one instance
//   serves all digits.
// - Top level holds the prescaler, 2-bit index, shadow registers and output
//   registers.
// TESTING (REFRESH_DIV=4 unless noted)
// - Reset: assert reset mid-cycle -> anode=1111, seg=1111111, dp=1
//   immediately, without a clock edge.
// - Capture/scan: update with A=3, B=2, AplusB=5, AminusB=1.
//   - anode follows 1110, 1101, 1011, 0111, dwelling 4 cycles each.
//   - seg shows 1, 5, 2, 3.
//   - dp stays 1 throughout.
// - Negative: A=2, B=5, AminusB=D.
//   - On digit 0: seg=7'b0100001 and dp=0.
//   - dp=1 on digits 1-3.
// - Mid-dwell update: during index 1, update AplusB from 5 to F.
//   - seg=7'b0001110 within 2 cycles.
//   - Dwell length is unchanged.
// - Blank: assert blank for 6 cycles -> anode=1111; deassert -> index has
//   kept advancing.
// - REFRESH_DIV=1: anode rotates every cycle, 1110 -> 1101 -> 1011 -> 0111 -> 1110.

Source files
------------

// File: rtl/result_display_scanner_pkg.sv
// Shared constants for the result display scanner: blank pattern, hex segment
// table and digit-index assignments.
package result_display_scanner_pkg;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit indices: position on the display for each captured value
    localparam logic [1:0] DIG_DIFF = 2'd0;
    localparam logic [1:0] DIG_SUM  = 2'd1;
    localparam logic [1:0] DIG_B    = 2'd2;
    localparam logic [1:0] DIG_A    = 2'd3;

    // Active-low {g,f,e,d,c,b,a} patterns; entry k is the glyph for hex digit k
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Look up the segment pattern for one hex nibble
    function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/result_display_scanner_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
    import result_display_scanner_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_seg(nibble_i);

endmodule

// File: rtl/result_display_scanner.sv
// Captures A, B, A+B and A-B into shadow registers and time-multiplexes them
// onto a 4-digit common-anode seven-segment display.
module result_display_scanner
    import result_display_scanner_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       update,
    input  logic       blank,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] AplusB,
    input  logic [3:0] AminusB,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    // Prescaler needs at least one bit even when every cycle is a digit step
    localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         a_q, b_q, sum_q, diff_q;
    logic [3:0]         anode_q, anode_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [3:0]         sel_nibble_s;
    logic [6:0]         sel_seg_s;

    // Advance the prescaler; step the digit index on its terminal count
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // Pick the shadow nibble belonging to the digit currently being scanned
    always_comb begin
        sel_nibble_s = diff_q;
        case (idx_q)
            DIG_DIFF: sel_nibble_s = diff_q;
            DIG_SUM:  sel_nibble_s = sum_q;
            DIG_B:    sel_nibble_s = b_q;
            DIG_A:    sel_nibble_s = a_q;
            default:  sel_nibble_s = diff_q;
        endcase
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble_i (sel_nibble_s),
        .seg_o    (sel_seg_s)
    );

    // Next display outputs; dp flags a negative difference on the diff digit
    always_comb begin
        anode_d = 4'b1111;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        if (blank) begin
            anode_d = 4'b1111;
            seg_d   = SEG_BLANK;
            dp_d    = 1'b1;
        end else begin
            anode_d = ~(4'b0001 << idx_q);
            seg_d   = sel_seg_s;
            dp_d    = ~((idx_q == DIG_DIFF) && (a_q < b_q));
        end
    end

    // Shadow registers load all four operands on an update strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= 4'd0;
            b_q    <= 4'd0;
            sum_q  <= 4'd0;
            diff_q <= 4'd0;
        end else if (update) begin
            a_q    <= A;
            b_q    <= B;
            sum_q  <= AplusB;
            diff_q <= AminusB;
        end
    end

    // Scan state: dwell prescaler and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Registered display outputs, all off during reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode_q <= 4'b1111;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign anode = anode_q;
    assign seg   = seg_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_result_display_scanner.sv
// Directed self-checking bench for result_display_scanner (REFRESH_DIV=4 and 1).
module tb_result_display_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       update = 1'b0;
    logic       blank = 1'b0;
    logic [3:0] A = 4'd0, B = 4'd0, AplusB = 4'd0, AminusB = 4'd0;
    logic [3:0] anode, anode1;
    logic [6:0] seg, seg1;
    logic       dp, dp1;

    int checks = 0;
    int passes = 0;

    logic [3:0] exp_anode [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    result_display_scanner #(.REFRESH_DIV(4)) dut (
        .clk(clk), .reset(reset), .update(update), .blank(blank),
        .A(A), .B(B), .AplusB(AplusB), .AminusB(AminusB),
        .anode(anode), .seg(seg), .dp(dp)
    );

    result_display_scanner #(.REFRESH_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .update(update), .blank(blank),
        .A(A), .B(B), .AplusB(AplusB), .AminusB(AminusB),
        .anode(anode1), .seg(seg1), .dp(dp1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset held over two edges, released while clk is low; next posedge is E1
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        A = 4'd3; B = 4'd2; AplusB = 4'd5; AminusB = 4'd1; update = 1'b1;
        do_reset();
        step();
        update = 1'b0;
        repeat (5) step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (anode !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1)
            $display("FAIL reset_async: anode=%b seg=%b dp=%b required 1111 1111111 1", anode, seg, dp);
        else passes++;
        checks++;
        if (anode1 !== 4'b1111 || seg1 !== 7'b1111111 || dp1 !== 1'b1)
            $display("FAIL reset_async_div1: anode=%b seg=%b dp=%b required 1111 1111111 1", anode1, seg1, dp1);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        step();
        checks++;
        if (anode !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1)
            $display("FAIL reset_release: anode=%b seg=%b dp=%b required 1110 1000000 1", anode, seg, dp);
        else passes++;
    endtask

    task automatic test_capture_scan();
        logic [6:0] exp_seg [4] = '{7'b1111001, 7'b0010010, 7'b0100100, 7'b0110000};
        A = 4'd3; B = 4'd2; AplusB = 4'd5; AminusB = 4'd1; update = 1'b1;
        do_reset();
        step();
        update = 1'b0;
        for (int n = 2; n <= 17; n++) begin
            int k;
            step();
            k = ((n - 1) / 4) % 4;
            checks++;
            if (anode !== exp_anode[k] || seg !== exp_seg[k] || dp !== 1'b1)
                $display("FAIL scan_e%0d: anode=%b seg=%b dp=%b required %b %b 1", n, anode, seg, dp, exp_anode[k], exp_seg[k]);
            else passes++;
        end
    endtask

    task automatic test_negative();
        logic [6:0] exp_seg [4] = '{7'b0100001, 7'b1111000, 7'b0010010, 7'b0100100};
        A = 4'd2; B = 4'd5; AplusB = 4'd7; AminusB = 4'hD; update = 1'b1;
        do_reset();
        step();
        update = 1'b0;
        for (int n = 2; n <= 16; n++) begin
            int k;
            logic edp;
            step();
            k = ((n - 1) / 4) % 4;
            edp = (k == 0) ? 1'b0 : 1'b1;
            checks++;
            if (anode !== exp_anode[k] || seg !== exp_seg[k] || dp !== edp)
                $display("FAIL negative_e%0d: anode=%b seg=%b dp=%b required %b %b %b", n, anode, seg, dp, exp_anode[k], exp_seg[k], edp);
            else passes++;
        end
    endtask

    task automatic test_mid_dwell_update();
        A = 4'd3; B = 4'd2; AplusB = 4'd5; AminusB = 4'd1; update = 1'b1;
        do_reset();
        step();
        update = 1'b0;
        repeat (5) step();
        AplusB = 4'hF; update = 1'b1;
        step();
        update = 1'b0;
        checks++;
        if (anode !== 4'b1101 || seg !== 7'b0010010)
            $display("FAIL mid_dwell_e7: anode=%b seg=%b required 1101 0010010", anode, seg);
        else passes++;
        step();
        checks++;
        if (anode !== 4'b1101 || seg !== 7'b0001110)
            $display("FAIL mid_dwell_e8: anode=%b seg=%b required 1101 0001110", anode, seg);
        else passes++;
        step();
        checks++;
        if (anode !== 4'b1011 || seg !== 7'b0100100)
            $display("FAIL mid_dwell_e9: anode=%b seg=%b required 1011 0100100", anode, seg);
        else passes++;
    endtask

    task automatic test_blank();
        A = 4'd3; B = 4'd2; AplusB = 4'd5; AminusB = 4'd1; update = 1'b1;
        do_reset();
        step();
        update = 1'b0;
        step();
        blank = 1'b1;
        for (int n = 3; n <= 8; n++) begin
            step();
            checks++;
            if (anode !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1)
                $display("FAIL blank_e%0d: anode=%b seg=%b dp=%b required 1111 1111111 1", n, anode, seg, dp);
            else passes++;
        end
        blank = 1'b0;
        step();
        checks++;
        if (anode !== 4'b1011 || seg !== 7'b0100100)
            $display("FAIL unblank_e9: anode=%b seg=%b required 1011 0100100", anode, seg);
        else passes++;
    endtask

    task automatic test_div1();
        A = 4'd0; B = 4'd0; AplusB = 4'd0; AminusB = 4'd0; update = 1'b0;
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            int k;
            step();
            k = (n - 1) % 4;
            checks++;
            if (anode1 !== exp_anode[k] || seg1 !== 7'b1000000)
                $display("FAIL div1_e%0d: anode=%b seg=%b required %b 1000000", n, anode1, seg1, exp_anode[k]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_capture_scan();
        test_negative();
        test_mid_dwell_update();
        test_blank();
        test_div1();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
